fifo_rd_arbiter: RTL and testbench
==================================

# fifo_rd_arbiter

Round-robin read-port arbiter for the byte FIFO read side. It shares one FIFO read port (`rdEn`/`dout`/`fifoEmpty`, all in the `rdClk` domain) among `NUM_REQ` consumers. It grants one consumer at a time for a bounded burst, drives `rdEn`, and routes each popped byte to the owning consumer with a one-hot valid. It sits between the FIFO read interface and downstream byte consumers.

## Interface
- `NUM_REQ`, 4: number of requesting consumers (2..8).
- `DATA_W`, 8: FIFO data width.
- `MAX_BURST`, 4: maximum pops per grant (1..15).
- `rdClk` input 1: read-domain clock, all logic on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `fifoEmpty` input 1: FIFO empty flag.
- `dout` input DATA_W: FIFO read data, valid the cycle after a pop.
- `rdEn` output 1: FIFO pop request.
- `req` input NUM_REQ: per-consumer request, level.
- `gnt` output NUM_REQ: one-hot current owner, registered.
- `rd_data` output DATA_W: delivered byte, registered.
- `rd_valid` output NUM_REQ: one-hot, 1-cycle pulse marking `rd_data` for that consumer.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE: if any `req` is high, pick the first requester at or after `rr_ptr` (cyclic search) and load `gnt`. Clear the burst counter. Go to READ next cycle.
- READ: `rdEn = !fifoEmpty && req[owner] && (cnt < MAX_BURST)`. This is combinational from `fifoEmpty`/`req`, so `rdEn` is never high while `fifoEmpty` is high. Each cycle with `rdEn` high increments `cnt`.
- READ exit to DRAIN when `cnt` reaches `MAX_BURST`, or when `req[owner]` is low. An empty FIFO alone does not end the burst; the owner waits.
- DRAIN: `rdEn` = 0. Stay until no pops are in flight (at most 2 cycles), then clear `gnt`, set `rr_ptr = owner+1` (wrapping at `NUM_REQ`), and go to IDLE.
- Data path, two-stage: `pop_d1` = registered `rdEn`. When `pop_d1` is high, register `dout` into `rd_data` and assert `rd_valid[owner]` for the next cycle.
- Each delivered byte goes to the consumer that was owner when it was popped. The owner cannot change while pops are in flight; DRAIN guarantees this.
- Consumers have no backpressure; a consumer that raises `req` must accept every `rd_valid` pulse.
- `cnt` width is clog2(MAX_BURST+1) and it never wraps.

## Timing
- Reset values: `rdEn`=0, `gnt`=0, `rd_data`=0, `rd_valid`=0, `busy`=0. Internally: state IDLE, `rr_ptr`=0, `cnt`=0, pipeline cleared.
- Grant latency: `req` high in cycle t (IDLE) → `gnt` high in t+1 → first `rdEn` possible in t+1.
- Pop latency: `rdEn` high in cycle t → `dout` valid in t+1 → `rd_valid`/`rd_data` in t+2.
- Back-to-back: with the FIFO non-empty, `rdEn` is high for `MAX_BURST` consecutive cycles.
- Minimum turnaround between grants: DRAIN plus IDLE, at least 3 cycles without a pop.
- Simultaneous `req` drop and final pop in the same cycle: the pop still counts, and its byte is delivered to the dropping consumer.
- `fifoEmpty` rising mid-burst: `rdEn` drops in that same cycle. Popping resumes when it falls, provided `req` is still held.
- `rst` mid-burst: all outputs clear immediately. In-flight bytes are discarded and not delivered; the FIFO-side pop, if any, is lost.

## Configuration
- `FIFO_RD_ARB_STATS_EN` defined: adds output `pop_count` (16 bits). It increments on each `rdEn` cycle, wraps at 0xFFFF→0, and resets to 0.
- `FIFO_RD_ARB_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset during READ with 2 pops in flight → outputs 0 next cycle, no `rd_valid` afterward. After release, `req[2]` gives `gnt`=4'b0100.
- `req`=4'b0001, FIFO holds 0x11..0x16, `MAX_BURST`=4 → 4 consecutive `rdEn`. `rd_valid`=4'b0001 with 0x11,0x12,0x13,0x14 starting 2 cycles after the first `rdEn`. `busy` falls after DRAIN/IDLE.
- `req`=4'b1111 held, FIFO always non-empty → grants in order 0,1,2,3,0. Each grant gets exactly 4 pops, and each byte's `rd_valid` bit matches its owner.
- FIFO empty after 2 pops during `req[1]`'s burst → `rdEn` low while empty. Two bytes are pushed 5 cycles later → 2 more pops, total 4, then handoff.
- `req[3]` drops after its 1st pop → DRAIN, 1 byte delivered to consumer 3, next grant goes to index 0.
- With `FIFO_RD_ARB_STATS_EN`: 70000 pops → `pop_count`=4464 (70000 mod 65536).

Source files
------------

// File: rtl/fifo_rd_arbiter_if.sv
// Read-side bundle shared by the byte FIFO, fifo_rd_arbiter and the downstream consumers.
interface fifo_rd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic               fifoEmpty;
  logic [DATA_W-1:0]  dout;
  logic               rdEn;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [DATA_W-1:0]  rd_data;
  logic [NUM_REQ-1:0] rd_valid;
  logic               busy;

  modport master (
    input  fifoEmpty, dout, req,
    output rdEn, gnt, rd_data, rd_valid, busy
  );

  modport slave (
    output fifoEmpty, dout, req,
    input  rdEn, gnt, rd_data, rd_valid, busy
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among NUM_REQ byte consumers in bounded bursts.
// Optional FIFO_RD_ARB_STATS_EN adds a 16-bit wrapping pop counter output (pop_count).
module fifo_rd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              rdClk,
  input  logic              rst,
`ifdef FIFO_RD_ARB_STATS_EN
  output logic [15:0]       pop_count,
`endif
  fifo_rd_arbiter_if.master bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   cand_idx;
  int                 cand_sum;
  logic               pick_found;
  logic               grant_load;
  logic               release_owner;
  logic [NUM_REQ-1:0] gnt_q;
  logic [CNT_W-1:0]   cnt;
  logic               rd_en;
  logic               pop_d1;
  logic [DATA_W-1:0]  rd_data_q;
  logic [NUM_REQ-1:0] rd_valid_q;

  // Cyclic search for the first requester at or after rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    cand_sum   = 0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = int'(rr_ptr) + i;
      if (cand_sum >= NUM_REQ) cand_sum = cand_sum - NUM_REQ;
      cand_idx = PTR_W'(cand_sum);
      if (!pick_found && bus.req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge rdClk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven here gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    rd_en         = 1'b0;
    grant_load    = 1'b0;
    release_owner = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_load = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        rd_en = !bus.fifoEmpty && bus.req[owner] && (cnt < CNT_W'(MAX_BURST));
        // An empty FIFO only stalls the owner; the burst ends on a full count or a dropped request.
        if (!bus.req[owner] || (rd_en && cnt == CNT_W'(MAX_BURST - 1)))
          state_next = DRAIN;
      end
      DRAIN: begin
        if (!pop_d1) begin
          release_owner = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments on all registered state so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge rdClk or posedge rst) begin
    if (rst) begin
      owner      <= '0;
      rr_ptr     <= '0;
      gnt_q      <= '0;
      cnt        <= '0;
      pop_d1     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      pop_d1     <= rd_en;
      // owner is frozen while pops are in flight, so it still names the consumer that popped this byte.
      rd_valid_q <= pop_d1 ? (NUM_REQ'(1) << owner) : '0;
      if (pop_d1) rd_data_q <= bus.dout;

      if (grant_load) begin
        owner <= pick_idx;
        gnt_q <= NUM_REQ'(1) << pick_idx;
        cnt   <= '0;
      end else if (rd_en) begin
        cnt <= cnt + 1'b1;
      end

      if (release_owner) begin
        gnt_q  <= '0;
        rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

`ifdef FIFO_RD_ARB_STATS_EN
  always_ff @(posedge rdClk or posedge rst) begin
    if (rst)        pop_count <= '0;
    else if (rd_en) pop_count <= pop_count + 16'd1;
  end
`endif

  assign bus.rdEn     = rd_en;
  assign bus.gnt      = gnt_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: behavioural byte FIFO, negedge monitor logs, one task per scenario.
module tb_fifo_rd_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  fifo_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

`ifdef FIFO_RD_ARB_STATS_EN
  logic [15:0] pop_count;
`endif

  fifo_rd_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .rdClk     (clk),
    .rst       (rst),
`ifdef FIFO_RD_ARB_STATS_EN
    .pop_count (pop_count),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: read data appears the cycle after a pop.
  logic [7:0] mem [1024];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] dout_q = 8'h00;

  assign bus.fifoEmpty = (wr_ptr == rd_ptr);
  assign bus.dout      = dout_q;

  always @(posedge clk) begin
    if (bus.rdEn) begin
      dout_q <= mem[rd_ptr[9:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor logs, sampled on the falling edge.
  int         cyc = 0;
  int         empty_viol = 0;
  int         pop_cyc [$];
  logic [3:0] pop_gnt [$];
  logic [7:0] dv_data [$];
  logic [3:0] dv_valid [$];
  int         dv_cyc [$];
  logic [3:0] gnt_log [$];
  logic [3:0] gnt_prev = 4'b0000;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.rdEn) begin
      pop_cyc.push_back(cyc + 1);
      pop_gnt.push_back(bus.gnt);
      if (bus.fifoEmpty) empty_viol <= empty_viol + 1;
    end
    if (bus.rd_valid != 4'b0000) begin
      dv_data.push_back(bus.rd_data);
      dv_valid.push_back(bus.rd_valid);
      dv_cyc.push_back(cyc + 1);
    end
    if (bus.gnt != gnt_prev && bus.gnt != 4'b0000) gnt_log.push_back(bus.gnt);
    gnt_prev <= bus.gnt;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[9:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic wait_pops(input int base, input int target, input int limit);
    int k;
    k = 0;
    while (pop_cyc.size() - base < target && k < limit) begin
      tick(1);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
    tick(3);
    @(negedge clk);
    checks++; if (bus.rdEn !== 1'b0) begin failures++; $display("FAIL reset_rdEn got %b exp 0", bus.rdEn); end
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt); end
    checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got %h exp 00", bus.rd_data); end
    checks++; if (bus.rd_valid !== 4'b0000) begin failures++; $display("FAIL reset_rd_valid got %b exp 0000", bus.rd_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_round_robin();
    int pb, db, gb, np, nd;
    logic [3:0] exp_g;
    logic [3:0] exp_log [5];
    exp_log = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    flush();
    pb = pop_cyc.size(); db = dv_data.size(); gb = gnt_log.size();
    for (int i = 0; i < 20; i++) push(8'h40 + 8'(i));
    bus.req = 4'b1111;
    wait_pops(pb, 20, 200);
    bus.req = 4'b0000;
    tick(8);
    np = pop_cyc.size() - pb;
    nd = dv_data.size() - db;
    checks++; if (np !== 20) begin failures++; $display("FAIL rr_pop_count got %0d exp 20", np); end
    checks++; if (nd !== 20) begin failures++; $display("FAIL rr_deliv_count got %0d exp 20", nd); end
    checks++; if (gnt_log.size() - gb !== 5) begin failures++; $display("FAIL rr_grant_count got %0d exp 5", gnt_log.size() - gb); end
    if (gnt_log.size() - gb >= 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (gnt_log[gb + i] !== exp_log[i]) begin
          failures++; $display("FAIL rr_grant_order[%0d] got %b exp %b", i, gnt_log[gb + i], exp_log[i]);
        end
      end
    end
    if (np >= 20 && nd >= 20) begin
      for (int i = 0; i < 20; i++) begin
        exp_g = 4'b0001 << ((i / 4) % 4);
        checks++; if (pop_gnt[pb + i] !== exp_g) begin failures++; $display("FAIL rr_pop_owner[%0d] got %b exp %b", i, pop_gnt[pb + i], exp_g); end
        checks++; if (dv_valid[db + i] !== exp_g) begin failures++; $display("FAIL rr_valid[%0d] got %b exp %b", i, dv_valid[db + i], exp_g); end
        checks++; if (dv_data[db + i] !== 8'h40 + 8'(i)) begin failures++; $display("FAIL rr_data[%0d] got %h exp %h", i, dv_data[db + i], 8'h40 + 8'(i)); end
      end
      checks++; if (pop_cyc[pb + 3] - pop_cyc[pb] !== 3) begin failures++; $display("FAIL rr_burst_span got %0d exp 3", pop_cyc[pb + 3] - pop_cyc[pb]); end
      checks++; if (pop_cyc[pb + 4] - pop_cyc[pb + 3] !== 4) begin failures++; $display("FAIL rr_turnaround got %0d exp 4", pop_cyc[pb + 4] - pop_cyc[pb + 3]); end
    end
  endtask

  task automatic test_single_burst();
    int pb, db, gb, c0, np, nd;
    flush();
    pb = pop_cyc.size(); db = dv_data.size(); gb = gnt_log.size();
    for (int i = 0; i < 6; i++) push(8'h11 + 8'(i));
    bus.req = 4'b0001;
    c0 = cyc;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_t0 got %b exp 0000", bus.gnt); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt_t1 got %b exp 0001", bus.gnt); end
    checks++; if (bus.rdEn !== 1'b1) begin failures++; $display("FAIL single_rdEn_t1 got %b exp 1", bus.rdEn); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy_t1 got %b exp 1", bus.busy); end
    @(posedge clk); #1;
    wait_pops(pb, 4, 50);
    bus.req = 4'b0000;
    tick(8);
    np = pop_cyc.size() - pb;
    nd = dv_data.size() - db;
    checks++; if (np !== 4) begin failures++; $display("FAIL single_pop_count got %0d exp 4", np); end
    checks++; if (nd !== 4) begin failures++; $display("FAIL single_deliv_count got %0d exp 4", nd); end
    if (np >= 4 && nd >= 4) begin
      checks++; if (pop_cyc[pb] !== c0 + 2) begin failures++; $display("FAIL single_first_pop_cycle got %0d exp %0d", pop_cyc[pb], c0 + 2); end
      checks++; if (pop_cyc[pb + 3] - pop_cyc[pb] !== 3) begin failures++; $display("FAIL single_consecutive got %0d exp 3", pop_cyc[pb + 3] - pop_cyc[pb]); end
      checks++; if (dv_cyc[db] - pop_cyc[pb] !== 2) begin failures++; $display("FAIL single_pop_latency got %0d exp 2", dv_cyc[db] - pop_cyc[pb]); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (dv_valid[db + i] !== 4'b0001) begin failures++; $display("FAIL single_valid[%0d] got %b exp 0001", i, dv_valid[db + i]); end
        checks++; if (dv_data[db + i] !== 8'h11 + 8'(i)) begin failures++; $display("FAIL single_data[%0d] got %h exp %h", i, dv_data[db + i], 8'h11 + 8'(i)); end
      end
    end
    checks++; if (gnt_log.size() - gb !== 1) begin failures++; $display("FAIL single_grant_count got %0d exp 1", gnt_log.size() - gb); end
    checks++; if (wr_ptr - rd_ptr !== 2) begin failures++; $display("FAIL single_fifo_left got %0d exp 2", wr_ptr - rd_ptr); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got %b exp 0", bus.busy); end
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_end got %b exp 0000", bus.gnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_empty_stall();
    int pb, db, gb, np, nd;
    flush();
    pb = pop_cyc.size(); db = dv_data.size(); gb = gnt_log.size();
    push(8'hA0); push(8'hA1);
    bus.req = 4'b0011;
    wait_pops(pb, 2, 50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.rdEn !== 1'b0) begin failures++; $display("FAIL stall_rdEn[%0d] got %b exp 0", i, bus.rdEn); end
      checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL stall_gnt[%0d] got %b exp 0010", i, bus.gnt); end
      @(posedge clk); #1;
    end
    push(8'hA2); push(8'hA3);
    wait_pops(pb, 4, 50);
    tick(8);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL stall_handoff_gnt got %b exp 0001", bus.gnt); end
    @(posedge clk); #1;
    bus.req = 4'b0000;
    tick(6);
    np = pop_cyc.size() - pb;
    nd = dv_data.size() - db;
    checks++; if (np !== 4) begin failures++; $display("FAIL stall_pop_count got %0d exp 4", np); end
    checks++; if (nd !== 4) begin failures++; $display("FAIL stall_deliv_count got %0d exp 4", nd); end
    if (np >= 4 && nd >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (pop_gnt[pb + i] !== 4'b0010) begin failures++; $display("FAIL stall_pop_owner[%0d] got %b exp 0010", i, pop_gnt[pb + i]); end
        checks++; if (dv_valid[db + i] !== 4'b0010) begin failures++; $display("FAIL stall_valid[%0d] got %b exp 0010", i, dv_valid[db + i]); end
        checks++; if (dv_data[db + i] !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL stall_data[%0d] got %h exp %h", i, dv_data[db + i], 8'hA0 + 8'(i)); end
      end
    end
    checks++; if (gnt_log.size() - gb !== 2) begin failures++; $display("FAIL stall_grant_count got %0d exp 2", gnt_log.size() - gb); end
    checks++; if (empty_viol !== 0) begin failures++; $display("FAIL rdEn_while_empty got %0d exp 0", empty_viol); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL stall_busy_end got %b exp 0", bus.busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_req_drop();
    int pb, db, gb, np, nd;
    logic [3:0] exp_v [3];
    exp_v = '{4'b1000, 4'b0001, 4'b0001};
    flush();
    pb = pop_cyc.size(); db = dv_data.size(); gb = gnt_log.size();
    push(8'hB0); push(8'hB1); push(8'hB2);
    bus.req = 4'b1000;
    wait_pops(pb, 1, 50);
    bus.req = 4'b0101;
    wait_pops(pb, 3, 50);
    bus.req = 4'b0000;
    tick(8);
    np = pop_cyc.size() - pb;
    nd = dv_data.size() - db;
    checks++; if (np !== 3) begin failures++; $display("FAIL drop_pop_count got %0d exp 3", np); end
    checks++; if (nd !== 3) begin failures++; $display("FAIL drop_deliv_count got %0d exp 3", nd); end
    if (np >= 3 && nd >= 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (pop_gnt[pb + i] !== exp_v[i]) begin failures++; $display("FAIL drop_pop_owner[%0d] got %b exp %b", i, pop_gnt[pb + i], exp_v[i]); end
        checks++; if (dv_valid[db + i] !== exp_v[i]) begin failures++; $display("FAIL drop_valid[%0d] got %b exp %b", i, dv_valid[db + i], exp_v[i]); end
        checks++; if (dv_data[db + i] !== 8'hB0 + 8'(i)) begin failures++; $display("FAIL drop_data[%0d] got %h exp %h", i, dv_data[db + i], 8'hB0 + 8'(i)); end
      end
    end
    checks++; if (gnt_log.size() - gb !== 2) begin failures++; $display("FAIL drop_grant_count got %0d exp 2", gnt_log.size() - gb); end
    if (gnt_log.size() - gb >= 2) begin
      checks++; if (gnt_log[gb + 1] !== 4'b0001) begin failures++; $display("FAIL drop_next_grant got %b exp 0001", gnt_log[gb + 1]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int pb, db, np, nd;
    flush();
    pb = pop_cyc.size(); db = dv_data.size();
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    bus.req = 4'b0001;
    wait_pops(pb, 2, 50);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.rdEn !== 1'b0) begin failures++; $display("FAIL midrst_rdEn got %b exp 0", bus.rdEn); end
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL midrst_gnt got %b exp 0000", bus.gnt); end
    checks++; if (bus.rd_valid !== 4'b0000) begin failures++; $display("FAIL midrst_rd_valid got %b exp 0000", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL midrst_rd_data got %h exp 00", bus.rd_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
    @(posedge clk); #1;
    bus.req = 4'b0000;
    tick(2);
    rst = 1'b0;
    tick(6);
    np = pop_cyc.size() - pb;
    nd = dv_data.size() - db;
    checks++; if (np !== 2) begin failures++; $display("FAIL midrst_pop_count got %0d exp 2", np); end
    checks++; if (nd !== 0) begin failures++; $display("FAIL midrst_no_delivery got %0d exp 0", nd); end
`ifdef FIFO_RD_ARB_STATS_EN
    checks++; if (pop_count !== 16'd0) begin failures++; $display("FAIL stats_after_reset got %0d exp 0", pop_count); end
`endif
    bus.req = 4'b0100;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL midrst_gnt_t0 got %b exp 0000", bus.gnt); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL midrst_regrant got %b exp 0100", bus.gnt); end
    checks++; if (bus.rdEn !== 1'b1) begin failures++; $display("FAIL midrst_regrant_rdEn got %b exp 1", bus.rdEn); end
    @(posedge clk); #1;
    bus.req = 4'b0000;
    tick(8);
    nd = dv_data.size() - db;
    checks++; if (nd !== 1) begin failures++; $display("FAIL midrst_after_deliv_count got %0d exp 1", nd); end
    if (nd >= 1) begin
      checks++; if (dv_data[db] !== 8'hC2) begin failures++; $display("FAIL midrst_after_data got %h exp C2", dv_data[db]); end
      checks++; if (dv_valid[db] !== 4'b0100) begin failures++; $display("FAIL midrst_after_valid got %b exp 0100", dv_valid[db]); end
    end
`ifdef FIFO_RD_ARB_STATS_EN
    checks++; if (pop_count !== 16'd1) begin failures++; $display("FAIL stats_count got %0d exp 1", pop_count); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 4'b0000;
    test_reset();
    test_round_robin();
    test_single_burst();
    test_empty_stall();
    test_req_drop();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
